// File: rtl/world_clock_pkg.sv
// Shared types and constants for the world-clock timekeeping path.
// Zone arithmetic helper used to derive the local hour from UTC.
package world_clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HR   = 2'd1,
        SET_MIN  = 2'd2,
        SET_ZONE = 2'd3
    } mode_t;

    localparam int ZONE_MIN      = -12;
    localparam int ZONE_MAX      = 14;
    localparam int HOURS_PER_DAY = 24;
    localparam int MINS_PER_HR   = 60;

    localparam logic [4:0]        HR_LAST  = 5'(HOURS_PER_DAY - 1);
    localparam logic [5:0]        MIN_LAST = 6'(MINS_PER_HR - 1);
    localparam logic signed [4:0] ZONE_LO  = 5'(ZONE_MIN);
    localparam logic signed [4:0] ZONE_HI  = 5'(ZONE_MAX);
    localparam logic signed [6:0] DAY_S7   = 7'(HOURS_PER_DAY);

    // A single +/-24 correction suffices since the raw sum stays within -12..37.
    function automatic logic [4:0] zone_hour(input logic [4:0] hr, input logic signed [4:0] zn);
        logic signed [6:0] sum;
        sum = $signed({2'b00, hr}) + 7'(zn);
        if (sum < 0)
            sum = sum + DAY_S7;
        else if (sum >= DAY_S7)
            sum = sum - DAY_S7;
        return sum[4:0];
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button step generator: one-cycle pulse on press edge, plus held-button repeat when AUTO_REPEAT_EN.
// Step fires on the edge sampling btn=1, btn_q=0; no backpressure, pulses are never held off.
module btn_repeat #(
    parameter int REPEAT_DELAY  = 6_000_000,
    parameter int REPEAT_PERIOD = 1_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic hold_en,
    output logic step
);

    logic btn_q;
    logic press;

    assign press = btn & ~btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            btn_q <= 1'b0;
        else
            btn_q <= btn;
    end

`ifdef AUTO_REPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             rep_step;

    // Counter holds cycles since the press edge; reloading keeps later steps PERIOD apart.
    assign rep_step = btn & hold_en & ~press & (hold_cnt == CNT_W'(REPEAT_DELAY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (!(btn && hold_en))
            hold_cnt <= '0;
        else if (press)
            hold_cnt <= CNT_W'(1);
        else if (rep_step)
            hold_cnt <= CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        else if (hold_cnt != '0)
            hold_cnt <= hold_cnt + CNT_W'(1);
    end

    assign step = press | rep_step;
`else
    logic unused_cfg;
    assign unused_cfg = hold_en | (REPEAT_DELAY != REPEAT_PERIOD);

    assign step = press;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// UTC timekeeping plus four-mode set FSM and zone offset; fields update 1 cycle after tick/press.
// No backpressure; optional held-button auto-repeat selected by AUTO_REPEAT_EN.
module time_set_ctrl
    import world_clock_pkg::*;
#(
    parameter int CLK_HZ        = 12_000_000,
    parameter int REPEAT_DELAY  = CLK_HZ / 2,
    parameter int REPEAT_PERIOD = CLK_HZ / 8
) (
    input  logic              clk12m,
    input  logic              reset,
    input  logic              clk1hz,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [1:0]        mode,
    output logic [4:0]        hours,
    output logic [5:0]        minutes,
    output logic [5:0]        seconds,
    output logic signed [4:0] zone,
    output logic [4:0]        local_hour,
    output logic              blank_hr,
    output logic              blank_min,
    output logic              blank_zone
);

    mode_t             mode_r, mode_nxt;
    logic [4:0]        hr_r, hr_nxt;
    logic [5:0]        min_r, min_nxt;
    logic [5:0]        sec_r, sec_nxt;
    logic signed [4:0] zone_r, zone_nxt;

    logic clk1hz_q;
    logic btn_mode_q;
    logic tick;
    logic mode_press;
    logic up_step, down_step;
    logic step_up, step_down;
    logic hold_en;
    logic time_runs;

    assign tick       = clk1hz & ~clk1hz_q;
    assign mode_press = btn_mode & ~btn_mode_q;
    assign hold_en    = (mode_r != RUN) & (btn_up ^ btn_down) & ~mode_press;

    btn_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_rep_up (
        .clk     (clk12m),
        .rst     (reset),
        .btn     (btn_up),
        .hold_en (hold_en),
        .step    (up_step)
    );

    btn_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_rep_down (
        .clk     (clk12m),
        .rst     (reset),
        .btn     (btn_down),
        .hold_en (hold_en),
        .step    (down_step)
    );

    // A mode press swallows any coincident step; opposing steps cancel.
    assign step_up   = up_step & ~down_step & ~mode_press;
    assign step_down = down_step & ~up_step & ~mode_press;
    assign time_runs = tick & ((mode_r == RUN) | (mode_r == SET_ZONE));

    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            mode_r     <= RUN;
            clk1hz_q   <= 1'b0;
            btn_mode_q <= 1'b0;
        end else begin
            mode_r     <= mode_nxt;
            clk1hz_q   <= clk1hz;
            btn_mode_q <= btn_mode;
        end
    end

    always_comb begin
        mode_nxt = mode_r;
        if (mode_press) begin
            case (mode_r)
                RUN:      mode_nxt = SET_HR;
                SET_HR:   mode_nxt = SET_MIN;
                SET_MIN:  mode_nxt = SET_ZONE;
                SET_ZONE: mode_nxt = RUN;
                default:  mode_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        hr_nxt   = hr_r;
        min_nxt  = min_r;
        sec_nxt  = sec_r;
        zone_nxt = zone_r;

        if (time_runs) begin
            if (sec_r == MIN_LAST) begin
                sec_nxt = '0;
                if (min_r == MIN_LAST) begin
                    min_nxt = '0;
                    hr_nxt  = (hr_r == HR_LAST) ? '0 : hr_r + 5'd1;
                end else begin
                    min_nxt = min_r + 6'd1;
                end
            end else begin
                sec_nxt = sec_r + 6'd1;
            end
        end

        if (mode_press && mode_r == RUN)
            sec_nxt = '0;

        case (mode_r)
            SET_HR: begin
                if (step_up)
                    hr_nxt = (hr_r == HR_LAST) ? '0 : hr_r + 5'd1;
                else if (step_down)
                    hr_nxt = (hr_r == '0) ? HR_LAST : hr_r - 5'd1;
            end
            SET_MIN: begin
                if (step_up)
                    min_nxt = (min_r == MIN_LAST) ? '0 : min_r + 6'd1;
                else if (step_down)
                    min_nxt = (min_r == '0) ? MIN_LAST : min_r - 6'd1;
            end
            SET_ZONE: begin
                if (step_up && zone_r < ZONE_HI)
                    zone_nxt = zone_r + 5'sd1;
                else if (step_down && zone_r > ZONE_LO)
                    zone_nxt = zone_r - 5'sd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            hr_r   <= '0;
            min_r  <= '0;
            sec_r  <= '0;
            zone_r <= '0;
        end else begin
            hr_r   <= hr_nxt;
            min_r  <= min_nxt;
            sec_r  <= sec_nxt;
            zone_r <= zone_nxt;
        end
    end

    assign mode       = mode_r;
    assign hours      = hr_r;
    assign minutes    = min_r;
    assign seconds    = sec_r;
    assign zone       = zone_r;
    assign local_hour = zone_hour(hr_r, zone_r);
    assign blank_hr   = (mode_r == SET_HR) & ~clk1hz;
    assign blank_min  = (mode_r == SET_MIN) & ~clk1hz;
    assign blank_zone = (mode_r == SET_ZONE) & ~clk1hz;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: table of operations with expected field values through a scoreboard queue,
// then hand sequences for blanking, held buttons, reset mid-hold and tick coinciding with a mode press.
module tb_time_set_ctrl;

    logic              clk12m = 1'b0;
    logic              reset;
    logic              clk1hz;
    logic              btn_mode, btn_up, btn_down;
    logic [1:0]        mode;
    logic [4:0]        hours;
    logic [5:0]        minutes;
    logic [5:0]        seconds;
    logic signed [4:0] zone;
    logic [4:0]        local_hour;
    logic              blank_hr, blank_min, blank_zone;

    int n_checks = 0;
    int n_err    = 0;

    time_set_ctrl #(
        .CLK_HZ        (12_000_000),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk12m     (clk12m),
        .reset      (reset),
        .clk1hz     (clk1hz),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .mode       (mode),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .zone       (zone),
        .local_hour (local_hour),
        .blank_hr   (blank_hr),
        .blank_min  (blank_min),
        .blank_zone (blank_zone)
    );

    always #5 clk12m = ~clk12m;

    typedef enum {OP_NONE, OP_TICK, OP_MODE, OP_UP, OP_DOWN, OP_UPDN, OP_MODEUP} op_e;

    typedef struct {
        int md;
        int hr;
        int mn;
        int sc;
        int zn;
        int lh;
    } exp_t;

    typedef struct {
        op_e  op;
        int   n;
        exp_t e;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];
    exp_t sb[$];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk12m);
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            clk1hz = 1'b1;
            cyc(2);
            clk1hz = 1'b0;
            cyc(2);
        end
    endtask

    task automatic do_press(input logic m, input logic u, input logic d, input int n);
        repeat (n) begin
            btn_mode = m;
            btn_up   = u;
            btn_down = d;
            cyc(1);
            btn_mode = 1'b0;
            btn_up   = 1'b0;
            btn_down = 1'b0;
            cyc(1);
        end
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        check({tag, ".mode"},       int'(mode),       e.md);
        check({tag, ".hours"},      int'(hours),      e.hr);
        check({tag, ".minutes"},    int'(minutes),    e.mn);
        check({tag, ".seconds"},    int'(seconds),    e.sc);
        check({tag, ".zone"},       int'(zone),       e.zn);
        check({tag, ".local_hour"}, int'(local_hour), e.lh);
    endtask

    initial begin
        exp_t e;
        int   exp_min;

        vecs[0]  = '{OP_NONE,   0, '{0,  0,  0,  0,   0,  0}};
        vecs[1]  = '{OP_TICK,   3, '{0,  0,  0,  3,   0,  0}};
        vecs[2]  = '{OP_MODE,   1, '{1,  0,  0,  0,   0,  0}};
        vecs[3]  = '{OP_DOWN,   2, '{1, 22,  0,  0,   0, 22}};
        vecs[4]  = '{OP_TICK,   2, '{1, 22,  0,  0,   0, 22}};
        vecs[5]  = '{OP_UP,     1, '{1, 23,  0,  0,   0, 23}};
        vecs[6]  = '{OP_MODE,   1, '{2, 23,  0,  0,   0, 23}};
        vecs[7]  = '{OP_DOWN,   1, '{2, 23, 59,  0,   0, 23}};
        vecs[8]  = '{OP_UPDN,   1, '{2, 23, 59,  0,   0, 23}};
        vecs[9]  = '{OP_TICK,   2, '{2, 23, 59,  0,   0, 23}};
        vecs[10] = '{OP_MODE,   1, '{3, 23, 59,  0,   0, 23}};
        vecs[11] = '{OP_TICK,  59, '{3, 23, 59, 59,   0, 23}};
        vecs[12] = '{OP_MODE,   1, '{0, 23, 59, 59,   0, 23}};
        vecs[13] = '{OP_TICK,   1, '{0,  0,  0,  0,   0,  0}};
        vecs[14] = '{OP_UP,     2, '{0,  0,  0,  0,   0,  0}};
        vecs[15] = '{OP_MODE,   1, '{1,  0,  0,  0,   0,  0}};
        vecs[16] = '{OP_UP,     1, '{1,  1,  0,  0,   0,  1}};
        vecs[17] = '{OP_MODE,   1, '{2,  1,  0,  0,   0,  1}};
        vecs[18] = '{OP_MODE,   1, '{3,  1,  0,  0,   0,  1}};
        vecs[19] = '{OP_DOWN,   3, '{3,  1,  0,  0,  -3, 22}};
        vecs[20] = '{OP_UP,    30, '{3,  1,  0,  0,  14, 15}};
        vecs[21] = '{OP_MODEUP, 1, '{0,  1,  0,  0,  14, 15}};
        vecs[22] = '{OP_MODE,   1, '{1,  1,  0,  0,  14, 15}};
        vecs[23] = '{OP_DOWN,   2, '{1, 23,  0,  0,  14, 13}};
        vecs[24] = '{OP_MODE,   1, '{2, 23,  0,  0,  14, 13}};
        vecs[25] = '{OP_MODE,   1, '{3, 23,  0,  0,  14, 13}};
        vecs[26] = '{OP_DOWN,  30, '{3, 23,  0,  0, -12, 11}};
        vecs[27] = '{OP_MODE,   1, '{0, 23,  0,  0, -12, 11}};

        reset    = 1'b1;
        clk1hz   = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        for (int i = 0; i < NV; i++) begin
            sb.push_back(vecs[i].e);
            case (vecs[i].op)
                OP_TICK:   do_tick(vecs[i].n);
                OP_MODE:   do_press(1'b1, 1'b0, 1'b0, vecs[i].n);
                OP_UP:     do_press(1'b0, 1'b1, 1'b0, vecs[i].n);
                OP_DOWN:   do_press(1'b0, 1'b0, 1'b1, vecs[i].n);
                OP_UPDN:   do_press(1'b0, 1'b1, 1'b1, vecs[i].n);
                OP_MODEUP: do_press(1'b1, 1'b1, 1'b0, vecs[i].n);
                default:   ;
            endcase
            cyc(1);
            e = sb.pop_front();
            check_fields($sformatf("v%0d", i), e);
        end

        // Blanking in SET_HR tracks ~clk1hz; a tick there leaves time frozen.
        do_press(1'b1, 1'b0, 1'b0, 1);
        check("blank_hr_low",     int'(blank_hr),   1);
        check("blank_min_in_hr",  int'(blank_min),  0);
        check("blank_zone_in_hr", int'(blank_zone), 0);
        clk1hz = 1'b1;
        cyc(1);
        check("blank_hr_high", int'(blank_hr), 0);
        cyc(1);
        clk1hz = 1'b0;
        cyc(1);
        check("blank_hr_again", int'(blank_hr), 1);
        check("hr_frozen_sec",  int'(seconds),  0);

        // Held up button in SET_MIN for 22 sampling edges.
        do_press(1'b1, 1'b0, 1'b0, 1);
        check("mode_set_min", int'(mode), 2);
`ifdef AUTO_REPEAT_EN
        exp_min = 4;
`else
        exp_min = 1;
`endif
        btn_up = 1'b1;
        cyc(22);
        btn_up = 1'b0;
        cyc(3);
        check("hold_minutes", int'(minutes), exp_min);
        check("hold_hours",   int'(hours),   23);

        do_press(1'b1, 1'b0, 1'b0, 1);
        check("blank_zone_low",    int'(blank_zone), 1);
        check("blank_min_in_zone", int'(blank_min),  0);

        // Asynchronous reset while a button is held in SET_ZONE.
        btn_up = 1'b1;
        cyc(3);
        #2 reset = 1'b1;
        #1;
        check("rst_mode",       int'(mode),       0);
        check("rst_hours",      int'(hours),      0);
        check("rst_minutes",    int'(minutes),    0);
        check("rst_seconds",    int'(seconds),    0);
        check("rst_zone",       int'(zone),       0);
        check("rst_local_hour", int'(local_hour), 0);
        check("rst_blank_hr",   int'(blank_hr),   0);
        check("rst_blank_min",  int'(blank_min),  0);
        check("rst_blank_zone", int'(blank_zone), 0);
        cyc(2);
        btn_up = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        check("post_rst_mode", int'(mode), 0);
        check("post_rst_zone", int'(zone), 0);

        // Tick coinciding with the mode press out of SET_ZONE counts as a running tick.
        do_press(1'b1, 1'b0, 1'b0, 3);
        check("mode_zone_again", int'(mode), 3);
        clk1hz   = 1'b1;
        btn_mode = 1'b1;
        cyc(1);
        btn_mode = 1'b0;
        cyc(1);
        clk1hz = 1'b0;
        cyc(2);
        check("tick_mode_mode", int'(mode),    0);
        check("tick_mode_sec",  int'(seconds), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
